// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
//   - size encodings of the CPU load/store port
//   - FSM state enumeration
//   - alignment check shared by the controller
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_RESP
  } state_t;

  // Reserved size is folded into the misaligned class so it takes the same
  // error path and never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for sub-word accesses (little-endian).
// Ports:
//   i_word    : word read from memory
//   i_off     : byte offset inside the word (addr[1:0])
//   i_size    : access size (byte/half/word)
//   i_uns     : 1 = zero-extend loads, 0 = sign-extend
//   i_wdata   : right-aligned store data
//   o_ld_data : extracted and extended load result
//   o_st_word : i_word with the addressed lane replaced by i_wdata
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word
);

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (size)
      SZ_BYTE: m[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) m[31:16] = wdata[15:0];
        else        m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign o_ld_data = load_extract(i_word, i_off, i_size, i_uns);
  assign o_st_word = store_merge(i_word, i_off, i_size, i_wdata);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the CPU data port and a word-wide memory with
// a 1-cycle registered read. Sub-word stores use read-modify-write; misaligned
// or reserved-size requests are answered with err and never touch memory.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req/we/size/uns     : request, store flag, size, zero-extend flag
//   addr/wdata          : byte address, right-aligned store data
//   rdata/ack/err       : response (rdata/err valid only while ack)
//   busy                : controller not idle (CPU stall)
//   mem_addr            : word address = addr[ADDR_W+1:2]
//   mem_re/mem_rdata    : read strobe, read data (valid the next cycle)
//   mem_we/mem_wdata    : write strobe, full word to write
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         w_ld_data;
  logic [31:0]         w_st_word;
  logic                w_mis;

  // Address bits above the memory window are intentionally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  assign w_mis = is_misaligned(size, addr[1:0]);

  dmem_lane_align u_align (
    .i_word    (mem_rdata),
    .i_off     (r_addr[1:0]),
    .i_size    (r_size),
    .i_uns     (r_uns),
    .i_wdata   (r_wdata),
    .o_ld_data (w_ld_data),
    .o_st_word (w_st_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != ST_IDLE);
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 32'h0;
    ack         = 1'b0;
    rdata       = 32'h0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_mis)                      w_state_nxt = ST_RESP;
          else if (we && size == SZ_WORD) w_state_nxt = ST_WR;
          else                            w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        mem_re      = !rst;
        w_state_nxt = ST_MERGE;
      end
      ST_MERGE: begin
        w_state_nxt = r_we ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        // Gating with rst keeps memory untouched when an access is aborted.
        mem_we      = !rst;
        mem_wdata   = r_wdata;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ack         = 1'b1;
        rdata       = r_rdata;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr = r_addr[ADDR_W+1:2];

  // Request capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_uns   <= uns;
            r_addr  <= addr[ADDR_W+1:0];
            r_wdata <= wdata;
            r_rdata <= 32'h0;
            r_err   <= w_mis;
          end
        end
        ST_MERGE: begin
          // r_wdata is reused to hold the merged word for the write cycle.
          if (r_we) r_wdata <= w_st_word;
          else      r_rdata <= w_ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  // Memory attached to the DUT: 1-cycle registered read, word write.
  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Behavioural reference: what one access should do, from the access rules.
  task automatic ref_access(input logic a_we, input logic [1:0] a_size, input logic a_uns,
                            input logic [31:0] a_addr, input logic [31:0] a_wdata,
                            output logic [31:0] e_rd, output logic e_err, output int e_lat,
                            output int e_re_cyc, output int e_we_cyc, output logic [31:0] e_wd);
    logic        mis;
    logic [31:0] w, mask, v;
    int          sh, idx;
    mis = (a_size == 2'd3) || (a_size == 2'd1 && a_addr[0]) ||
          (a_size == 2'd2 && a_addr[1:0] != 2'd0);
    idx  = int'(a_addr[17:2]);
    w    = ref_mem[idx];
    sh   = int'(a_addr[1:0]) * 8;
    mask = (a_size == 2'd0) ? 32'hFF : (a_size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    e_rd = 32'h0; e_err = 1'b0; e_re_cyc = 0; e_we_cyc = 0; e_wd = 32'h0;
    if (mis) begin
      e_err = 1'b1; e_lat = 1;
    end else if (a_we && a_size == 2'd2) begin
      e_wd = a_wdata; ref_mem[idx] = a_wdata;
      e_lat = 2; e_we_cyc = 1;
    end else if (a_we) begin
      e_wd = (w & ~(mask << sh)) | ((a_wdata & mask) << sh);
      ref_mem[idx] = e_wd;
      e_lat = 4; e_re_cyc = 1; e_we_cyc = 3;
    end else begin
      v = (w >> sh) & mask;
      if (!a_uns && a_size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!a_uns && a_size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      e_rd = v; e_lat = 3; e_re_cyc = 1;
    end
  endtask

  // Drive one request from an idle DUT (called on a negedge) and observe it.
  task automatic access(input logic a_we, input logic [1:0] a_size, input logic a_uns,
                        input logic [31:0] a_addr, input logic [31:0] a_wdata,
                        output logic [31:0] o_rd, output logic o_err, output int o_lat,
                        output int o_re_cyc, output int o_we_cyc, output int o_nre,
                        output int o_nwe, output logic [31:0] o_wd, output logic o_busy_ok,
                        output logic o_addr_ok, output logic o_idle_ok);
    o_rd = 32'h0; o_err = 1'b0; o_lat = 0; o_re_cyc = 0; o_we_cyc = 0;
    o_nre = 0; o_nwe = 0; o_wd = 32'h0; o_busy_ok = 1'b1; o_addr_ok = 1'b1;
    req = 1'b1; we = a_we; size = a_size; uns = a_uns; addr = a_addr; wdata = a_wdata;
    for (int k = 1; k <= 12 && o_lat == 0; k++) begin
      @(negedge clk);
      if (!busy) o_busy_ok = 1'b0;
      if (mem_re) begin
        o_nre++;
        if (o_re_cyc == 0) o_re_cyc = k;
        if (mem_addr !== a_addr[17:2]) o_addr_ok = 1'b0;
      end
      if (mem_we) begin
        o_nwe++;
        o_we_cyc = k;
        o_wd = mem_wdata;
        if (mem_addr !== a_addr[17:2]) o_addr_ok = 1'b0;
      end
      if (ack) begin
        o_lat = k; o_rd = rdata; o_err = err;
      end
    end
    req = 1'b0;
    @(negedge clk);
    o_idle_ok = !busy && !ack && !mem_re && !mem_we && rdata == 32'h0 && !err;
  endtask

  task automatic run_check(input string nm, input logic a_we, input logic [1:0] a_size,
                           input logic a_uns, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                           input logic use_tab, input logic [31:0] t_rd, input logic t_err,
                           input int t_lat, input logic [31:0] t_wd);
    logic [31:0] e_rd, e_wd, o_rd, o_wd;
    logic        e_err, o_err, o_busy_ok, o_addr_ok, o_idle_ok;
    int          e_lat, e_re, e_we, o_lat, o_re, o_we, o_nre, o_nwe;
    ref_access(a_we, a_size, a_uns, a_addr, a_wdata, e_rd, e_err, e_lat, e_re, e_we, e_wd);
    access(a_we, a_size, a_uns, a_addr, a_wdata, o_rd, o_err, o_lat, o_re, o_we,
           o_nre, o_nwe, o_wd, o_busy_ok, o_addr_ok, o_idle_ok);
    if (use_tab) begin
      chk({nm, ".tab_lat"}, o_lat, t_lat);
      chk({nm, ".tab_err"}, {31'h0, o_err}, {31'h0, t_err});
      if (!a_we && !t_err) chk({nm, ".tab_rdata"}, o_rd, t_rd);
      if (a_we && !t_err)  chk({nm, ".tab_wdata"}, o_wd, t_wd);
    end
    chk({nm, ".lat"}, o_lat, e_lat);
    chk({nm, ".err"}, {31'h0, o_err}, {31'h0, e_err});
    if (!a_we && !e_err) chk({nm, ".rdata"}, o_rd, e_rd);
    chk({nm, ".re_cycle"}, o_re, e_re);
    chk({nm, ".we_cycle"}, o_we, e_we);
    chk({nm, ".re_count"}, o_nre, (e_re != 0) ? 1 : 0);
    chk({nm, ".we_count"}, o_nwe, (e_we != 0) ? 1 : 0);
    if (e_we != 0) chk({nm, ".mem_wdata"}, o_wd, e_wd);
    chk({nm, ".busy"}, {31'h0, o_busy_ok}, 32'h1);
    chk({nm, ".mem_addr"}, {31'h0, o_addr_ok}, 32'h1);
    chk({nm, ".idle_after"}, {31'h0, o_idle_ok}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tab [13];

  initial begin
    logic saw_ack;
    int   lat_dummy;

    tab[0]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hA1B2C3D4, 1'b0, 3, 32'h0};
    tab[1]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFA1, 1'b0, 3, 32'h0};
    tab[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000A1, 1'b0, 3, 32'h0};
    tab[3]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFFA1B2, 1'b0, 3, 32'h0};
    tab[4]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h0000C3D4, 1'b0, 3, 32'h0};
    tab[5]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 32'h0,        1'b0, 4, 32'hA1B255D4};
    tab[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hA1B255D4, 1'b0, 3, 32'h0};
    tab[7]  = '{1'b1, 2'd2, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    tab[8]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 3, 32'h0};
    tab[9]  = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 32'h0};
    tab[10] = '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1, 32'h0};
    tab[11] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b1, 1, 32'h0};
    tab[12] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        1'b0, 4, 32'h123455D4};

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 32'h9E37_79B9 * i;
      ref_mem[i] = 32'h9E37_79B9 * i;
    end
    mem[4]     = 32'hA1B2C3D4;
    ref_mem[4] = 32'hA1B2C3D4;
    mem_rdata  = 32'h0;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rdata[15:0], 8'h0, ack, err, busy, mem_re, mem_we, 3'b0},  32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {27'h0, ack, err, busy, mem_re, mem_we}, 32'h0);

    for (int i = 0; i < 13; i++)
      run_check($sformatf("tab%0d", i), tab[i].we, tab[i].size, tab[i].uns, tab[i].addr,
                tab[i].wdata, 1'b1, tab[i].exp_rd, tab[i].exp_err, tab[i].exp_lat, tab[i].exp_wd);

    // Reset during the write cycle of a byte store: no write, no ack, back to idle.
    saw_ack = 1'b0;
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h11; wdata = 32'h000000EE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
    end
    chk("abort.in_wr", {31'h0, mem_we}, 32'h1);
    rst = 1'b1; req = 1'b0;
    #1;
    chk("abort.we_gated", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    if (ack) saw_ack = 1'b1;
    chk("abort.outputs", {27'h0, ack, err, busy, mem_re, mem_we}, 32'h0);
    chk("abort.rdata", rdata, 32'h0);
    chk("abort.mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("abort.mem_wdata", mem_wdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
    end
    chk("abort.no_ack", {31'h0, saw_ack}, 32'h0);
    chk("abort.mem_word", mem[4], ref_mem[4]);
    run_check("abort.readback", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h123455D4, 1'b0, 3, 32'h0);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        r_we_v, r_uns_v;
      logic [1:0]  r_size_v;
      logic [31:0] r_addr_v, r_wdata_v;
      r_we_v    = 1'($urandom_range(0, 1));
      r_uns_v   = 1'($urandom_range(0, 1));
      r_size_v  = 2'($urandom_range(0, 3));
      r_addr_v  = 32'($urandom_range(0, 255));
      r_wdata_v = $urandom;
      // Occasional high address bits must be ignored by the word index.
      if ($urandom_range(0, 7) == 0) r_addr_v = r_addr_v | 32'hFFFC_0000;
      run_check($sformatf("rnd%0d", i), r_we_v, r_size_v, r_uns_v, r_addr_v, r_wdata_v,
                1'b0, 32'h0, 1'b0, 0, 32'h0);
    end

    lat_dummy = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== ref_mem[i]) lat_dummy++;
    chk("final_mem_image", lat_dummy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencing controller between the CPU load/store port and a word-wide data memory with a 1-cycle registered read. It performs byte and halfword loads with sign or zero extension. Sub-word stores are done as read-modify-write so the memory needs no byte enables. Misaligned accesses are rejected with an error response and never touch memory.

Parameters:
ADDR_W, 16, word-index width of the data memory; the memory word address is addr[ADDR_W+1:2].

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  1  access request; held high with all fields stable until ack
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as misaligned
uns  in  1  load zero-extend (1) or sign-extend (0)
addr  in  32  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rdata  out  32  load result, valid only while ack is high
ack  out  1  one-cycle completion pulse
err  out  1  misaligned or reserved size; valid only while ack is high
busy  out  1  high whenever state is not IDLE (CPU stall)
mem_addr  out  ADDR_W  word address to memory
mem_re  out  1  read strobe; memory data is valid on mem_rdata the next cycle
mem_rdata  in  32  memory read data
mem_we  out  1  write strobe, one cycle
mem_wdata  out  32  full merged word to write

Behaviour:
- Reset values: all outputs are 0, state is IDLE, internal request registers are cleared.
- FSM states: IDLE, RD, MERGE, WR, RESP.
- IDLE behaviour:
  - req is sampled only in IDLE; the controller captures we/size/uns/addr/wdata into registers.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size=11): go to RESP with err=1.
  - Word store: go to WR.
  - Any other request: go to RD.
- RD: mem_re=1 and mem_addr=addr_q word index. Next state is MERGE.
- MERGE: mem_rdata is valid in this cycle.
  - Load: extract the lane into rdata_q, then go to RESP.
  - Store: build the merged word into wdata_q, then go to WR.
- WR: mem_we=1 and mem_wdata=wdata_q (or the full word for a word store). Next state is RESP.
- RESP: ack=1; rdata and err are driven from registers. Next state is IDLE.
- Latency, counted from the req sample cycle T0 to the ack cycle:
  - misaligned: T1
  - word store: T2
  - load: T3
  - sub-word store: T4
- Handshake: the requester sees ack in RESP. In the next cycle (controller back in IDLE) it either drops req or presents a new request. A still-high req in that cycle counts as a new transaction. There is no pipelining; at most one access is in flight.
- Lanes are little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1]: 0 selects [15:0], 1 selects [31:16]
  - loads sign- or zero-extend the selected lane to 32 bits per uns.
- Merge: only the addressed lane is replaced with wdata's low byte or half; all other bits keep mem_rdata.
- mem_re, mem_we, ack and busy are decoded from the registered state, so they are glitch-free. mem_we and mem_re are additionally gated by !rst, so no memory access occurs in a cycle where rst=1.
- Reset mid-operation: the next edge returns to IDLE, no ack is issued for the aborted access, and memory is untouched if rst was high during the WR cycle.
- Outside RESP, rdata=0 and err=0.

Decomposition:
- Shared package dmem_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
- One combinational sub-module, dmem_lane_align, with two functions:
  - load extract: (word, offset, size, uns) -> rdata
  - store merge: (word, offset, size, wdata) -> merged word
- Top module holds the FSM and all request/result registers.

Test Plan (preload mem word 0x10 = 0xA1B2C3D4):
1. Word load at addr 0x10 -> mem_re at T1, ack at T3 with rdata=0xA1B2C3D4, err=0, busy high during T1..T3.
2. Byte and half loads:
   - byte at 0x13, uns=0 -> 0xFFFFFFA1
   - byte at 0x13, uns=1 -> 0x000000A1
   - half at 0x12, uns=0 -> 0xFFFFA1B2
   - half at 0x10, uns=1 -> 0x0000C3D4
3. Byte store wdata=0x00000055 at 0x11 -> mem_re at T1, single mem_we at T3 with mem_wdata=0xA1B255D4, ack at T4; a following word load of 0x10 returns 0xA1B255D4.
4. Word store 0xDEADBEEF at 0x14 -> no mem_re, mem_we at T1, ack at T2; a readback returns 0xDEADBEEF.
5. Misaligned and reserved requests:
   - half at 0x11 -> ack at T1 with err=1, no mem_re/mem_we
   - word at 0x12 -> ack at T1 with err=1, no mem_re/mem_we
   - size=11 -> ack at T1 with err=1, no mem_re/mem_we
6. rst=1 during the WR cycle of a byte store -> mem_we stays 0, no ack, state returns to IDLE, all outputs 0, and the memory word is unchanged.
